// File: rtl/dkong3_snd_cmd_sched.sv
// dkong3_snd_cmd_sched
// Queues command bytes from the main CPU and hands them to two sub CPUs.
// Each hand-off loads a presentation register and pulses the sub CPU's NMI.
// The scheduler then waits for the sub CPU to read the byte (I_ACK), or for
// a timeout to expire.
//
// Scheduler A serves ports 0/1 and drives O_SUB1_NMIn.
// Scheduler B serves port 2 and drives O_SUB2_NMIn.
//
// Build option: DKONG3_SND_CMD_FIFO_EN
//   defined   -> each port has a FIFO_DEPTH-entry queue; the scheduler runs
//                IDLE -> LOAD -> NMI -> WAIT_ACK.
//   undefined -> no queues. A write lands in the presentation register on
//                the next edge and starts IDLE -> NMI. A write while the
//                byte is still pending overwrites it without a new NMI.
//                O_FULL and O_OVF read 0.
//
// Ports
//   I_SUBCLK      clock, rising edge
//   I_SUB_RESETn  synchronous active-low reset
//   I_CPU_CE      sub-CPU clock-enable tick; times the NMI width and the timeout
//   I_WR/I_PORT/I_DATA  command write strobe, target port (3 ignored), byte
//   I_ACK[2:0]    per-port read acknowledge
//   O_SUB1INP0/O_SUB1INP1/O_SUB2INP  presented command bytes
//   O_SUB1_NMIn/O_SUB2_NMIn          active-low NMI pulses
//   O_FULL[2:0]/O_OVF[2:0]           queue full / sticky overflow per port
module dkong3_snd_cmd_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NMI_LEN     = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       I_SUBCLK,
  input  logic       I_SUB_RESETn,
  input  logic       I_CPU_CE,
  input  logic       I_WR,
  input  logic [1:0] I_PORT,
  input  logic [7:0] I_DATA,
  input  logic [2:0] I_ACK,
  output logic [7:0] O_SUB1INP0,
  output logic [7:0] O_SUB1INP1,
  output logic [7:0] O_SUB2INP,
  output logic       O_SUB1_NMIn,
  output logic       O_SUB2_NMIn,
  output logic [2:0] O_FULL,
  output logic [2:0] O_OVF
);

  localparam int unsigned NPORT  = 3;
  localparam int unsigned NSCHED = 2;
  localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CNT_W  = (TO_W > 4) ? TO_W : 4;
  localparam logic [CNT_W-1:0] NMI_LAST = CNT_W'(NMI_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, NMI, WAIT_ACK} state_t;

  // Scheduler that owns port n.
  function automatic int owner(input int n);
    return (n == 2) ? 1 : 0;
  endfunction

  // Ports owned by scheduler s.
  function automatic logic [2:0] own_mask(input int s);
    return (s == 1) ? 3'b100 : 3'b011;
  endfunction

  state_t            state   [NSCHED];
  logic [CNT_W-1:0]  cnt     [NSCHED];
  logic [NSCHED-1:0] nmin;
  logic [NPORT-1:0]  pending;
  logic [7:0]        out_reg [NPORT];

  logic [NPORT-1:0]  wr_hit_c;
  logic [NPORT-1:0]  ack_left_c;
  logic [NSCHED-1:0] timeout_c;
  logic [NSCHED-1:0] done_c;

  // Decode the write strobe per port; port 3 matches nothing.
  always_comb begin
    wr_hit_c = '0;
    for (int n = 0; n < NPORT; n++) wr_hit_c[n] = I_WR && (I_PORT == 2'(n));
  end

`ifdef DKONG3_SND_CMD_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]       mem   [NPORT][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr  [NPORT];
  logic [PTR_W-1:0] rptr  [NPORT];
  logic [CW-1:0]    count [NPORT];
  logic [NPORT-1:0] full_q, ovf_q;

  logic [NPORT-1:0] nonempty_c, pop_c, push_c, drop_c;
  logic [CW-1:0]    count_next_c [NPORT];

  // A full queue still accepts a write when the same cycle pops it.
  always_comb begin
    nonempty_c = '0;
    pop_c      = '0;
    push_c     = '0;
    drop_c     = '0;
    for (int n = 0; n < NPORT; n++) begin
      nonempty_c[n]   = (count[n] != '0);
      pop_c[n]        = nonempty_c[n] && (state[owner(n)] == LOAD);
      push_c[n]       = wr_hit_c[n] && ((count[n] != DEPTH_C) || pop_c[n]);
      drop_c[n]       = wr_hit_c[n] && !push_c[n];
      count_next_c[n] = count[n] + CW'(push_c[n]) - CW'(pop_c[n]);
    end
  end

  // Queue storage; the pointers and counts define what is valid.
  always_ff @(posedge I_SUBCLK) begin
    for (int n = 0; n < NPORT; n++)
      if (push_c[n]) mem[n][wptr[n]] <= I_DATA;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge I_SUBCLK) begin
    if (!I_SUB_RESETn) begin
      for (int n = 0; n < NPORT; n++) begin
        wptr[n]  <= '0;
        rptr[n]  <= '0;
        count[n] <= '0;
      end
      full_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int n = 0; n < NPORT; n++) begin
        if (push_c[n]) wptr[n] <= wptr[n] + PTR_W'(1);
        if (pop_c[n])  rptr[n] <= rptr[n] + PTR_W'(1);
        count[n]  <= count_next_c[n];
        full_q[n] <= (count_next_c[n] == DEPTH_C);
        if (drop_c[n]) ovf_q[n] <= 1'b1;
      end
    end
  end

  assign O_FULL = full_q;
  assign O_OVF  = ovf_q;
`else
  assign O_FULL = '0;
  assign O_OVF  = '0;
`endif

  // Acks apply before any state change. In the queue-less build a fresh
  // write re-arms its port's pending bit.
  always_comb begin
    ack_left_c = pending & ~I_ACK;
`ifndef DKONG3_SND_CMD_FIFO_EN
    ack_left_c = ack_left_c | wr_hit_c;
`endif
    timeout_c = '0;
    done_c    = '1;
    for (int s = 0; s < NSCHED; s++)
      timeout_c[s] = I_CPU_CE && (cnt[s] == TO_LAST);
    for (int n = 0; n < NPORT; n++)
      if (ack_left_c[n]) done_c[owner(n)] = 1'b0;
  end

  // Both schedulers; cnt counts NMI ticks in NMI and timeout ticks in WAIT_ACK.
  always_ff @(posedge I_SUBCLK) begin
    if (!I_SUB_RESETn) begin
      for (int s = 0; s < NSCHED; s++) begin
        state[s] <= IDLE;
        cnt[s]   <= '0;
      end
      nmin    <= '1;
      pending <= '0;
      for (int n = 0; n < NPORT; n++) out_reg[n] <= '0;
    end else begin
      for (int s = 0; s < NSCHED; s++) begin
        case (state[s])
          IDLE: begin
`ifdef DKONG3_SND_CMD_FIFO_EN
            if (|(nonempty_c & own_mask(s))) state[s] <= LOAD;
`else
            if (|((wr_hit_c | pending) & own_mask(s))) begin
              state[s] <= NMI;
              nmin[s]  <= 1'b0;
              cnt[s]   <= '0;
            end
`endif
          end
          LOAD: begin
`ifdef DKONG3_SND_CMD_FIFO_EN
            for (int n = 0; n < NPORT; n++)
              if (owner(n) == s && nonempty_c[n]) begin
                out_reg[n] <= mem[n][rptr[n]];
                pending[n] <= 1'b1;
              end
`endif
            state[s] <= NMI;
            nmin[s]  <= 1'b0;
            cnt[s]   <= '0;
          end
          NMI: begin
            if (I_CPU_CE) begin
              if (cnt[s] == NMI_LAST) begin
                nmin[s]  <= 1'b1;
                state[s] <= WAIT_ACK;
                cnt[s]   <= '0;
              end else begin
                cnt[s] <= cnt[s] + CNT_W'(1);
              end
            end
          end
          WAIT_ACK: begin
            for (int n = 0; n < NPORT; n++)
              if (owner(n) == s) pending[n] <= ack_left_c[n] && !timeout_c[s];
            if (timeout_c[s] || done_c[s]) begin
              state[s] <= IDLE;
              cnt[s]   <= '0;
            end else if (I_CPU_CE) begin
              cnt[s] <= cnt[s] + CNT_W'(1);
            end
          end
          default: state[s] <= IDLE;
        endcase
      end
`ifndef DKONG3_SND_CMD_FIFO_EN
      // Direct write; placed last so it wins over the scheduler's pending update.
      for (int n = 0; n < NPORT; n++)
        if (wr_hit_c[n]) begin
          out_reg[n] <= I_DATA;
          pending[n] <= 1'b1;
        end
`endif
    end
  end

  assign O_SUB1INP0  = out_reg[0];
  assign O_SUB1INP1  = out_reg[1];
  assign O_SUB2INP   = out_reg[2];
  assign O_SUB1_NMIn = nmin[0];
  assign O_SUB2_NMIn = nmin[1];

endmodule

// File: tb/tb_dkong3_snd_cmd_sched.sv
// Directed bench for dkong3_snd_cmd_sched (default parameters).
// Inputs change 2 time units after each rising edge, so they are stable
// before the next edge. Outputs are sampled at that same point.
// I_CPU_CE toggles every cycle: it is high on every second cycle.
module tb_dkong3_snd_cmd_sched;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce    = 1'b0;
  logic       wr    = 1'b0;
  logic [1:0] port  = 2'd0;
  logic [7:0] data  = 8'h00;
  logic [2:0] ack   = 3'b000;
  logic [7:0] sub1inp0, sub1inp1, sub2inp;
  logic       sub1_nmin, sub2_nmin;
  logic [2:0] full, ovf;

  int errors = 0;
  int checks = 0;

  dkong3_snd_cmd_sched dut (
    .I_SUBCLK(clk), .I_SUB_RESETn(rst_n), .I_CPU_CE(ce), .I_WR(wr),
    .I_PORT(port), .I_DATA(data), .I_ACK(ack),
    .O_SUB1INP0(sub1inp0), .O_SUB1INP1(sub1inp1), .O_SUB2INP(sub2inp),
    .O_SUB1_NMIn(sub1_nmin), .O_SUB2_NMIn(sub2_nmin),
    .O_FULL(full), .O_OVF(ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    ce = ~ce;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic nmi(input int which);
    return (which == 0) ? sub1_nmin : sub2_nmin;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [1:0] p, input logic [7:0] d);
    port = p; data = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic pulse_ack(input logic [2:0] a);
    ack = a;
    cyc();
    ack = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Returns the CE ticks seen while NMI is low, or -1 if NMI never rises.
  task automatic wait_nmi_high(input int which, output int ticks);
    int g = 0;
    ticks = 0;
    while (nmi(which) == 1'b0 && g < 200) begin
      if (ce) ticks++;
      cyc();
      g++;
    end
    if (nmi(which) == 1'b0) ticks = -1;
  endtask

  // Returns the cycles waited for NMI to fall, or -1 after lim cycles.
  task automatic wait_nmi_low(input int which, input int lim, output int n);
    n = 0;
    while (nmi(which) == 1'b1 && n < lim) begin
      cyc();
      n++;
    end
    if (nmi(which) == 1'b1) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({sub1inp0, sub1inp1, sub2inp} !== 24'h0) begin errors++;
      $display("FAIL reset_outputs got %h exp 000000", {sub1inp0, sub1inp1, sub2inp}); end
    checks++; if ({sub1_nmin, sub2_nmin} !== 2'b11) begin errors++;
      $display("FAIL reset_nmi got %b exp 11", {sub1_nmin, sub2_nmin}); end
    checks++; if ({full, ovf} !== 6'b0) begin errors++;
      $display("FAIL reset_full_ovf got %b exp 000000", {full, ovf}); end
    write(2'd3, 8'hFF);
    repeat (4) cyc();
    checks++; if ({sub1_nmin, sub2_nmin, sub1inp0, sub1inp1, sub2inp, ovf} !== {2'b11, 24'h0, 3'b0}) begin
      errors++;
      $display("FAIL port3_ignored got nmi=%b data=%h ovf=%b exp nmi=11 data=000000 ovf=000",
               {sub1_nmin, sub2_nmin}, {sub1inp0, sub1inp1, sub2inp}, ovf);
    end
  endtask

`ifdef DKONG3_SND_CMD_FIFO_EN
  task automatic test_latency();
    int t;
    port = 2'd2; data = 8'h5A; wr = 1'b1;
    cyc();                           // t+1
    wr = 1'b0;
    checks++; if ({sub2_nmin, sub2inp} !== {1'b1, 8'h00}) begin errors++;
      $display("FAIL lat_t1 got nmi=%b data=%h exp nmi=1 data=00", sub2_nmin, sub2inp); end
    cyc();                           // t+2, LOAD
    checks++; if ({sub2_nmin, sub2inp} !== {1'b1, 8'h00}) begin errors++;
      $display("FAIL lat_t2 got nmi=%b data=%h exp nmi=1 data=00", sub2_nmin, sub2inp); end
    cyc();                           // t+3
    checks++; if ({sub2_nmin, sub2inp} !== {1'b0, 8'h5A}) begin errors++;
      $display("FAIL lat_t3 got nmi=%b data=%h exp nmi=0 data=5a", sub2_nmin, sub2inp); end
    checks++; if ({sub1_nmin, sub1inp0, sub1inp1} !== {1'b1, 16'h0}) begin errors++;
      $display("FAIL lat_sub1_quiet got nmi=%b data=%h exp nmi=1 data=0000", sub1_nmin, {sub1inp0, sub1inp1}); end
    wait_nmi_high(1, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL lat_nmi_ticks got %0d exp 4", t); end
    pulse_ack(3'b100);
  endtask

  task automatic test_sub1_pair();
    int t, n;
    bit low_seen = 0;
    write(2'd0, 8'h11);
    write(2'd1, 8'h22);
    wait_nmi_low(0, 10, n);
    checks++; if ({n >= 0, sub1inp0, sub1inp1} !== {1'b1, 8'h11, 8'h22}) begin errors++;
      $display("FAIL pair_load got nmi_seen=%0d data=%h exp nmi_seen=1 data=1122", n >= 0, {sub1inp0, sub1inp1}); end
    wait_nmi_high(0, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL pair_single_nmi got %0d ticks exp 4", t); end
    pulse_ack(3'b001);
    write(2'd0, 8'h44);
    repeat (6) begin if (!sub1_nmin) low_seen = 1; cyc(); end
    checks++; if ({low_seen, sub1inp0} !== {1'b0, 8'h11}) begin errors++;
      $display("FAIL pair_wait_port1 got nmi_low=%0d data=%h exp nmi_low=0 data=11", low_seen, sub1inp0); end
    pulse_ack(3'b010);
    wait_nmi_low(0, 10, n);
    checks++; if ({n >= 0, sub1inp0, sub1inp1} !== {1'b1, 8'h44, 8'h22}) begin errors++;
      $display("FAIL pair_next got nmi_seen=%0d data=%h exp nmi_seen=1 data=4422", n >= 0, {sub1inp0, sub1inp1}); end
    wait_nmi_high(0, t);
    pulse_ack(3'b001);
  endtask

  task automatic test_overflow();
    int t, n;
    bit low_seen = 0;
    for (int i = 0; i < 5; i++) write(2'd0, 8'hA0 + 8'(i));
    checks++; if ({sub1inp0, full, ovf} !== {8'hA0, 3'b001, 3'b000}) begin errors++;
      $display("FAIL ovf_fill got data=%h full=%b ovf=%b exp data=a0 full=001 ovf=000", sub1inp0, full, ovf); end
    write(2'd0, 8'hA5);
    checks++; if ({full, ovf} !== {3'b001, 3'b001}) begin errors++;
      $display("FAIL ovf_drop got full=%b ovf=%b exp full=001 ovf=001", full, ovf); end
    for (int k = 1; k <= 4; k++) begin
      wait_nmi_high(0, t);
      pulse_ack(3'b001);
      wait_nmi_low(0, 10, n);
      checks++; if ({n >= 0, sub1inp0} !== {1'b1, 8'hA0 + 8'(k)}) begin errors++;
        $display("FAIL ovf_drain%0d got nmi_seen=%0d data=%h exp nmi_seen=1 data=%h", k, n >= 0, sub1inp0, 8'hA0 + 8'(k)); end
    end
    wait_nmi_high(0, t);
    pulse_ack(3'b001);
    repeat (20) begin if (!sub1_nmin) low_seen = 1; cyc(); end
    checks++; if ({low_seen, full, ovf} !== {1'b0, 3'b000, 3'b001}) begin errors++;
      $display("FAIL ovf_dropped got nmi_low=%0d full=%b ovf=%b exp nmi_low=0 full=000 ovf=001", low_seen, full, ovf); end
  endtask

  task automatic test_timeout();
    int t, n, tk = 0, g = 0;
    write(2'd2, 8'hB1);
    write(2'd2, 8'hB2);
    wait_nmi_low(1, 10, n);
    checks++; if (sub2inp !== 8'hB1) begin errors++; $display("FAIL to_first got %h exp b1", sub2inp); end
    wait_nmi_high(1, t);
    while (sub2_nmin && g < 1000) begin if (ce) tk++; cyc(); g++; end
    // Timeout fires on tick 255; IDLE and LOAD add at most one more tick.
    checks++; if (!(tk >= 255 && tk <= 256) || sub2_nmin !== 1'b0) begin errors++;
      $display("FAIL to_ticks got %0d nmi=%b exp 255..256 nmi=0", tk, sub2_nmin); end
    checks++; if (sub2inp !== 8'hB2) begin errors++; $display("FAIL to_next got %h exp b2", sub2inp); end
    wait_nmi_high(1, t);
    pulse_ack(3'b100);
  endtask

  task automatic test_reset_mid_nmi();
    int n;
    bit low_seen = 0;
    for (int i = 0; i < 4; i++) write(2'd0, 8'hC0 + 8'(i));
    wait_nmi_low(0, 10, n);
    checks++; if ({sub1_nmin, sub1inp0} !== {1'b0, 8'hC0}) begin errors++;
      $display("FAIL rst_pre got nmi=%b data=%h exp nmi=0 data=c0", sub1_nmin, sub1inp0); end
    rst_n = 1'b0;
    cyc();
    checks++; if ({sub1_nmin, sub2_nmin, sub1inp0, sub1inp1, sub2inp, full, ovf} !== {2'b11, 24'h0, 6'b0}) begin
      errors++;
      $display("FAIL rst_mid got nmi=%b data=%h full=%b ovf=%b exp nmi=11 data=000000 full=000 ovf=000",
               {sub1_nmin, sub2_nmin}, {sub1inp0, sub1inp1, sub2inp}, full, ovf);
    end
    rst_n = 1'b1;
    repeat (30) begin if (!(sub1_nmin && sub2_nmin)) low_seen = 1; cyc(); end
    checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL rst_discard got nmi_low=%0d exp 0", low_seen); end
  endtask
`else
  task automatic test_port2();
    int t;
    write(2'd2, 8'h5A);
    checks++; if ({sub2_nmin, sub2inp} !== {1'b0, 8'h5A}) begin errors++;
      $display("FAIL p2_start got nmi=%b data=%h exp nmi=0 data=5a", sub2_nmin, sub2inp); end
    checks++; if ({sub1_nmin, sub1inp0, sub1inp1} !== {1'b1, 16'h0}) begin errors++;
      $display("FAIL p2_sub1_quiet got nmi=%b data=%h exp nmi=1 data=0000", sub1_nmin, {sub1inp0, sub1inp1}); end
    wait_nmi_high(1, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL p2_nmi_ticks got %0d exp 4", t); end
    pulse_ack(3'b100);
    write(2'd2, 8'h33);
    checks++; if ({sub2_nmin, sub2inp} !== {1'b0, 8'h33}) begin errors++;
      $display("FAIL p2_rearm got nmi=%b data=%h exp nmi=0 data=33", sub2_nmin, sub2inp); end
    wait_nmi_high(1, t);
    pulse_ack(3'b100);
  endtask

  task automatic test_sub1_pair();
    int t, t0;
    bit low_seen = 0;
    write(2'd0, 8'h11);
    t0 = (ce && !sub1_nmin) ? 1 : 0;
    write(2'd1, 8'h22);
    checks++; if ({sub1_nmin, sub2_nmin, sub1inp0, sub1inp1} !== {2'b01, 8'h11, 8'h22}) begin errors++;
      $display("FAIL pair_start got nmi=%b data=%h exp nmi=01 data=1122", {sub1_nmin, sub2_nmin}, {sub1inp0, sub1inp1}); end
    wait_nmi_high(0, t);
    checks++; if (t0 + t !== 4) begin errors++; $display("FAIL pair_single_nmi got %0d ticks exp 4", t0 + t); end
    pulse_ack(3'b001);
    write(2'd0, 8'h44);
    repeat (3) begin if (!sub1_nmin) low_seen = 1; cyc(); end
    checks++; if ({low_seen, sub1inp0} !== {1'b0, 8'h44}) begin errors++;
      $display("FAIL pair_overwrite got nmi_low=%0d data=%h exp nmi_low=0 data=44", low_seen, sub1inp0); end
    pulse_ack(3'b011);
    write(2'd1, 8'h55);
    checks++; if ({sub1_nmin, sub1inp0, sub1inp1} !== {1'b0, 8'h44, 8'h55}) begin errors++;
      $display("FAIL pair_idle_restart got nmi=%b data=%h exp nmi=0 data=4455", sub1_nmin, {sub1inp0, sub1inp1}); end
    pulse_ack(3'b011);               // arrives during NMI: ignored
    wait_nmi_high(0, t);
    write(2'd0, 8'h66);
    low_seen = 0;
    repeat (3) begin if (!sub1_nmin) low_seen = 1; cyc(); end
    checks++; if ({low_seen, sub1inp0} !== {1'b0, 8'h66}) begin errors++;
      $display("FAIL pair_early_ack got nmi_low=%0d data=%h exp nmi_low=0 data=66", low_seen, sub1inp0); end
    pulse_ack(3'b011);
  endtask

  task automatic test_timeout();
    int t, tk = 0;
    bit low_seen = 0;
    write(2'd2, 8'hC1);
    wait_nmi_high(1, t);
    while (tk < 250) begin if (ce) tk++; cyc(); end
    write(2'd2, 8'hC2);
    repeat (3) begin if (!sub2_nmin) low_seen = 1; cyc(); end
    checks++; if ({low_seen, sub2inp} !== {1'b0, 8'hC2}) begin errors++;
      $display("FAIL to_before got nmi_low=%0d data=%h exp nmi_low=0 data=c2", low_seen, sub2inp); end
    repeat (30) begin if (!sub2_nmin) low_seen = 1; cyc(); end
    checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL to_quiet got nmi_low=%0d exp 0", low_seen); end
    write(2'd2, 8'hC3);
    checks++; if ({sub2_nmin, sub2inp} !== {1'b0, 8'hC3}) begin errors++;
      $display("FAIL to_after got nmi=%b data=%h exp nmi=0 data=c3", sub2_nmin, sub2inp); end
    wait_nmi_high(1, t);
    pulse_ack(3'b100);
  endtask

  task automatic test_reset_mid_nmi();
    bit low_seen = 0;
    write(2'd2, 8'h99);
    write(2'd0, 8'h12);
    checks++; if ({sub1_nmin, sub2_nmin} !== 2'b00) begin errors++;
      $display("FAIL rst_pre got nmi=%b exp 00", {sub1_nmin, sub2_nmin}); end
    rst_n = 1'b0;
    cyc();
    checks++; if ({sub1_nmin, sub2_nmin, sub1inp0, sub1inp1, sub2inp, full, ovf} !== {2'b11, 24'h0, 6'b0}) begin
      errors++;
      $display("FAIL rst_mid got nmi=%b data=%h full=%b ovf=%b exp nmi=11 data=000000 full=000 ovf=000",
               {sub1_nmin, sub2_nmin}, {sub1inp0, sub1inp1, sub2inp}, full, ovf);
    end
    rst_n = 1'b1;
    repeat (10) begin if (!(sub1_nmin && sub2_nmin)) low_seen = 1; cyc(); end
    checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL rst_quiet got nmi_low=%0d exp 0", low_seen); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DKONG3_SND_CMD_FIFO_EN
    test_latency();
    test_sub1_pair();
    test_overflow();
    test_timeout();
    test_reset_mid_nmi();
`else
    test_port2();
    test_sub1_pair();
    test_timeout();
    test_reset_mid_nmi();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dkong3_snd_cmd_sched.md
DKONG3_SND_CMD_SCHED -- requirements
Module: dkong3_snd_cmd_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per command queue (power of 2, 2..16).
REQ-002 SHALL have parameter NMI_LEN, default 4, NMI low width in I_CPU_CE ticks (1..15).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, I_CPU_CE ticks spent in WAIT_ACK before forced exit.
REQ-004 I_SUBCLK  in  1  sole clock; all logic on rising edge.
REQ-005 I_SUB_RESETn  in  1  reset, synchronous, active-low.
REQ-006 I_CPU_CE  in  1  sub-CPU clock-enable strobe, one I_SUBCLK cycle wide.
REQ-007 I_WR  in  1  main-CPU command write strobe, one cycle wide.
REQ-008 I_PORT  in  2  target port: 0 = sub1 port 0, 1 = sub1 port 1, 2 = sub2 port; 3 = ignored.
REQ-009 I_DATA  in  8  command byte.
REQ-010 I_ACK  in  3  per-port read acknowledge pulse from sub-CPU bus decode.
REQ-011 O_SUB1INP0, O_SUB1INP1, O_SUB2INP  out  8 each  presented command bytes.
REQ-012 O_SUB1_NMIn, O_SUB2_NMIn  out  1 each  active-low NMI to sub CPU 1 / 2.
REQ-013 O_FULL  out  3  per-port queue full; O_OVF  out  3  per-port sticky overflow.

Function
REQ-014 Each port SHALL own a FIFO_DEPTH-entry FIFO with a count of width clog2(FIFO_DEPTH)+1.
REQ-015 I_WR with I_PORT<=2 SHALL push I_DATA if count<FIFO_DEPTH or a pop occurs that cycle; otherwise drop it and set that O_OVF bit.
REQ-016 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 O_FULL[n] SHALL equal (count[n]==FIFO_DEPTH), registered.
REQ-018 Two schedulers SHALL run independently: A owns ports 0,1 and O_SUB1_NMIn; B owns port 2 and O_SUB2_NMIn.
REQ-019 States: IDLE, LOAD, NMI, WAIT_ACK.
REQ-020 IDLE -> LOAD when any owned FIFO non-empty; otherwise stay.
REQ-021 LOAD (one cycle): pop every owned non-empty FIFO into its output register, set its pending bit; -> NMI.
REQ-022 NMI: drive NMIn low starting the LOAD->NMI cycle, counting I_CPU_CE ticks; after NMI_LEN ticks NMIn returns high, -> WAIT_ACK.
REQ-023 WAIT_ACK: I_ACK[n] clears pending[n]; when no owned pending bit remains -> IDLE.
REQ-024 WAIT_ACK SHALL exit to IDLE after ACK_TIMEOUT I_CPU_CE ticks, clearing owned pending bits; output registers keep their values.
REQ-025 I_ACK outside WAIT_ACK SHALL be ignored; I_ACK and state change in the same cycle: ack applied first.
REQ-026 Latency: I_WR at cycle t into empty FIFO, scheduler IDLE -> LOAD at t+2, output register valid and NMIn low at t+3.
REQ-027 Output registers SHALL change only in LOAD.

Reset
REQ-028 I_SUB_RESETn low at a clock edge SHALL, regardless of state: FIFOs empty, pointers 0, schedulers IDLE, pending 0, counters 0, outputs 8'h00, NMIn 1, O_FULL 0, O_OVF 0.
REQ-029 Reset mid-NMI SHALL deassert NMIn on the next edge; queued commands are discarded.

Configuration
REQ-030 Macro DKONG3_SND_CMD_FIFO_EN defined: FIFOs as specified.
REQ-031 Macro undefined: no FIFOs; I_WR writes the output register directly (next cycle) and starts the scheduler (IDLE -> NMI directly, no LOAD); a write while pending overwrites the register and does not restart NMI; O_FULL and O_OVF tied 0.

Verification
REQ-032 Reset, write 8'h5A to port 2 -> O_SUB2INP=8'h5A and O_SUB2_NMIn low at t+3 for 4 CPU_CE ticks; sub1 outputs unchanged.
REQ-033 Write 8'h11 to port 0 and 8'h22 to port 1 in consecutive cycles -> single NMI on sub1, both bytes presented; IDLE only after I_ACK=3'b011.
REQ-034 Five writes to port 0 with no ack -> first byte presented, remaining four queued, O_FULL[0]=1; sixth write -> O_OVF[0]=1, byte dropped.
REQ-035 No ack after NMI -> IDLE after 255 CPU_CE ticks; next queued byte loaded with a new NMI.
REQ-036 Assert reset during NMI with 3 bytes queued -> next edge: NMIn=1, outputs 8'h00, O_FULL=0, no further NMI.
